button_event_ctrl: RTL



---
 rtl/btn_event_pkg.sv | 18 +
 rtl/btn_event_slot.sv | 54 +++++
 rtl/button_event_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// Shared constants for the button event controller: event codes and FSM state encoding.
package btn_event_pkg;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  localparam logic [1:0] ST_LOCKOUT = 2'b00;
  localparam logic [1:0] ST_IDLE    = 2'b01;
  localparam logic [1:0] ST_PRESSED = 2'b10;
  localparam logic [1:0] ST_HELD    = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_slot.sv
// Single-entry valid/ready event register with a sticky overrun flag for dropped events.
module btn_event_slot
  import btn_event_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_code,
  input  logic       ready,
  input  logic       clr,
  output logic       valid,
  output logic [1:0] code,
  output logic       overrun
);

  logic       valid_q;
  logic [1:0] code_q;
  logic       overrun_q;
  logic       load;
  logic       drop;

  // An accept in the same cycle frees the entry, so a push may load alongside it.
  assign load = push & (~valid_q | ready);
  assign drop = push & valid_q & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= EV_NONE;
    end else if (load) begin
      valid_q <= 1'b1;
      code_q  <= push_code;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
      code_q  <= EV_NONE;
    end
  end

  // A new drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign valid   = valid_q;
  assign code    = code_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies a debounced button level into SHORT / LONG / REPEAT events behind a valid/ready slot.
// Auto-repeat from the HELD state is built only when BTN_AUTO_REPEAT_EN is defined.
module button_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int LONG_PRESS_COUNT = 12_000_000,
  parameter int REPEAT_COUNT     = 2_400_000,
  parameter bit IN_ACTIVE_LOW    = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       in_sig,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ready,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int CNT_W = $clog2(max_int(LONG_PRESS_COUNT, REPEAT_COUNT) + 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_COUNT - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);
`endif

  logic             act;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             push;
  logic [1:0]       push_code;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  assign act = in_sig ^ IN_ACTIVE_LOW;

  // Thresholds compare against the pre-increment count, so the event is emitted
  // on the very sample that completes the required number of active cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    push_code = EV_NONE;
    case (state)
      ST_LOCKOUT: begin
        if (!act) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (act) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (act) begin
          if (cnt == LONG_LAST) begin
            push      = 1'b1;
            push_code = EV_LONG;
            state_nxt = ST_HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end else begin
          push      = 1'b1;
          push_code = EV_SHORT;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_HELD: begin
        if (act) begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt == REP_LAST) begin
            push      = 1'b1;
            push_code = EV_REPEAT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
`else
          cnt_nxt = '0;
`endif
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_LOCKOUT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_LOCKOUT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  btn_event_slot u_slot (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_code (push_code),
    .ready     (event_ready),
    .clr       (clr_overrun),
    .valid     (event_valid),
    .code      (event_code),
    .overrun   (overrun)
  );

endmodule
